// File: rtl/hs_npu_mem_rd_arbiter_if.sv
// Signal bundles for the NPU read arbiter: client-side read request/response and AXI4 read master.
// A transfer completes on a rising clk edge where valid and ready are both high; valid never waits on ready.
interface hs_npu_rd_req_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_arvalid;
    logic [NUM_REQ-1:0]    req_arready;
    logic [NUM_REQ*32-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]  req_arlen;
    logic [NUM_REQ-1:0]    req_rvalid;
    logic [NUM_REQ-1:0]    req_rready;
    logic [31:0]           req_rdata;
    logic                  req_rlast;
    logic [1:0]            req_rresp;

    modport master (
        output req_arvalid, req_araddr, req_arlen, req_rready,
        input  req_arready, req_rvalid, req_rdata, req_rlast, req_rresp
    );
    modport slave (
        input  req_arvalid, req_araddr, req_arlen, req_rready,
        output req_arready, req_rvalid, req_rdata, req_rlast, req_rresp
    );
endinterface

interface hs_npu_rd_mem_if;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [7:0]  mem_arid;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [7:0]  mem_rid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;

    modport master (
        output mem_arvalid, mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_rready,
        input  mem_arready, mem_rvalid, mem_rid, mem_rdata, mem_rresp, mem_rlast
    );
    modport slave (
        input  mem_arvalid, mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst, mem_rready,
        output mem_arready, mem_rvalid, mem_rid, mem_rdata, mem_rresp, mem_rlast
    );
endinterface

// File: rtl/hs_npu_mem_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between NUM_REQ fetch clients, one burst in flight.
// Optional per-client beat counters are built when HS_NPU_RD_ARB_PERF_EN is defined.
module hs_npu_mem_rd_arbiter #(
    parameter int         NUM_REQ = 2,
    parameter logic [7:0] ID_BASE = 8'h10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hs_npu_rd_req_if.slave        req,
    hs_npu_rd_mem_if.master       mem,
    output logic                  err,
    input  logic                  err_clr,
    output logic [NUM_REQ*32-1:0] perf_beats,
    input  logic                  perf_clr,
    output logic [1:0]            o_dbg_state
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gnt;
    logic [31:0]   r_addr;
    logic [7:0]    r_len;
    logic [8:0]    r_beat;
    logic          r_err;

    logic [IW-1:0] w_sel;
    logic          w_sel_vld;
    logic [2:0]    w_idx;
    logic          w_rready;
    logic          w_hs;
    logic          w_err_set;
    logic [7:0]    w_id;

    assign w_id        = ID_BASE | 8'(r_gnt);
    assign w_rready    = req.req_rready[r_gnt];
    assign w_hs        = (r_state == DATA) && mem.mem_rvalid && w_rready;
    assign err         = r_err;
    assign o_dbg_state = r_state;

    assign mem.mem_arsize  = 3'b010;
    assign mem.mem_arburst = 2'b01;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = 3'(r_ptr) + 3'(k);
            if (w_idx >= 3'(NUM_REQ)) begin
                w_idx = w_idx - 3'(NUM_REQ);
            end
            if (!w_sel_vld && req.req_arvalid[w_idx[IW-1:0]]) begin
                w_sel_vld = 1'b1;
                w_sel     = w_idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        req.req_arready     = '0;
        req.req_rvalid      = '0;
        req.req_rdata       = '0;
        req.req_rlast       = 1'b0;
        req.req_rresp       = '0;
        mem.mem_arvalid     = 1'b0;
        mem.mem_arid        = '0;
        mem.mem_araddr      = '0;
        mem.mem_arlen       = '0;
        mem.mem_rready      = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst_n so the accept pulse is also held low while reset is asserted.
                if (w_sel_vld && rst_n) begin
                    req.req_arready[w_sel] = 1'b1;
                    w_state_nxt            = ADDR;
                end
            end
            ADDR: begin
                mem.mem_arvalid = 1'b1;
                mem.mem_arid    = w_id;
                mem.mem_araddr  = r_addr;
                mem.mem_arlen   = r_len;
                if (mem.mem_arready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                req.req_rvalid[r_gnt] = mem.mem_rvalid;
                req.req_rdata         = mem.mem_rdata;
                req.req_rlast         = mem.mem_rlast;
                req.req_rresp         = mem.mem_rresp;
                mem.mem_rready        = w_rready;
                if (w_hs && mem.mem_rlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Beats keep flowing after an error; only the sticky flag records it.
    always_comb begin
        w_err_set = 1'b0;
        if (mem.mem_rvalid && (r_state != DATA)) begin
            w_err_set = 1'b1;
        end
        if (w_hs) begin
            if (mem.mem_rid != w_id) begin
                w_err_set = 1'b1;
            end
            if (mem.mem_rlast && (r_beat != {1'b0, r_len})) begin
                w_err_set = 1'b1;
            end
            if (!mem.mem_rlast && (r_beat > {1'b0, r_len})) begin
                w_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_addr <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_err  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_sel_vld) begin
                r_gnt  <= w_sel;
                r_addr <= req.req_araddr[32*w_sel +: 32];
                r_len  <= req.req_arlen[8*w_sel +: 8];
            end
            if (r_state == ADDR) begin
                r_beat <= '0;
            end else if (w_hs && (r_beat != 9'h1FF)) begin
                r_beat <= r_beat + 9'd1;
            end
            if (w_hs && mem.mem_rlast) begin
                r_ptr <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

`ifdef HS_NPU_RD_ARB_PERF_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        logic [31:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (perf_clr) begin
                r_cnt <= '0;
            end else if (w_hs && (r_gnt == IW'(gi)) && (r_cnt != 32'hFFFF_FFFF)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign perf_beats[32*gi +: 32] = r_cnt;
    end
`else
    logic w_perf_clr_unused;
    assign w_perf_clr_unused = perf_clr;
    assign perf_beats        = '0;
`endif

endmodule

// File: tb/tb_hs_npu_mem_rd_arbiter.sv
// Self-checking bench for hs_npu_mem_rd_arbiter: directed steps plus randomized bursts against a
// round-robin/queue reference model. Define HS_NPU_RD_ARB_PERF_EN to expect live beat counters.
module tb_hs_npu_mem_rd_arbiter;
    localparam int         NUM_REQ = 2;
    localparam logic [7:0] ID_BASE = 8'h10;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  err_clr;
    logic                  perf_clr;
    logic                  err;
    logic [NUM_REQ*32-1:0] perf_beats;
    logic [1:0]            dbg_state;

    hs_npu_rd_req_if #(.NUM_REQ(NUM_REQ)) req_if ();
    hs_npu_rd_mem_if mem_if ();

    hs_npu_mem_rd_arbiter #(.NUM_REQ(NUM_REQ), .ID_BASE(ID_BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_if),
        .mem         (mem_if),
        .err         (err),
        .err_clr     (err_clr),
        .perf_beats  (perf_beats),
        .perf_clr    (perf_clr),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          m_ptr;
    bit          m_err;
    logic [31:0] m_perf [NUM_REQ];
    logic [31:0] cl_addr [NUM_REQ];
    logic [7:0]  cl_len [NUM_REQ];
    logic [31:0] exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic int exp_grant(input logic [NUM_REQ-1:0] mask);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic clear_inputs();
        req_if.req_arvalid = '0;
        req_if.req_araddr  = '0;
        req_if.req_arlen   = '0;
        req_if.req_rready  = '0;
        mem_if.mem_arready = 1'b0;
        mem_if.mem_rvalid  = 1'b0;
        mem_if.mem_rid     = '0;
        mem_if.mem_rdata   = '0;
        mem_if.mem_rresp   = '0;
        mem_if.mem_rlast   = 1'b0;
        err_clr            = 1'b0;
        perf_clr           = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_err = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_perf[i] = '0;
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arready"}, req_if.req_arready, 0);
        chk({tag, "_rvalid"}, req_if.req_rvalid, 0);
        chk({tag, "_rdata"}, req_if.req_rdata, 0);
        chk({tag, "_rlast"}, req_if.req_rlast, 0);
        chk({tag, "_rresp"}, req_if.req_rresp, 0);
        chk({tag, "_arvalid"}, mem_if.mem_arvalid, 0);
        chk({tag, "_arid"}, mem_if.mem_arid, 0);
        chk({tag, "_araddr"}, mem_if.mem_araddr, 0);
        chk({tag, "_arlen"}, mem_if.mem_arlen, 0);
        chk({tag, "_arsize"}, mem_if.mem_arsize, 3'b010);
        chk({tag, "_arburst"}, mem_if.mem_arburst, 2'b01);
        chk({tag, "_mrready"}, mem_if.mem_rready, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_perf"}, perf_beats, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        chk_all_zero("reset");
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic chk_perf(input string tag);
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef HS_NPU_RD_ARB_PERF_EN
            chk(tag, perf_beats[32*i +: 32], m_perf[i]);
`else
            chk(tag, perf_beats[32*i +: 32], 0);
`endif
        end
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [7:0] l);
        req_if.req_araddr[32*c +: 32] = a;
        req_if.req_arlen[8*c +: 8]    = l;
        cl_addr[c]                    = a;
        cl_len[c]                     = l;
    endtask

    // Raise the given requests in IDLE; checks the accept pulse against the round-robin model.
    task automatic request(input logic [NUM_REQ-1:0] mask, output int g);
        req_if.req_arvalid = mask;
        #1;
        g = exp_grant(mask);
        chk("arready", req_if.req_arready, onehot(g));
        chk("req_state_idle", dbg_state, 0);
        cyc();
    endtask

    function automatic logic [31:0] perf_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Memory responder + client sink for one granted burst. nbeats may differ from arlen+1.
    task automatic serve(input int g, input int nbeats, input int ar_delay, input int rmode,
                         input bit bad_rid, input int gap_pct, input logic [31:0] data_base);
        logic [31:0] d;
        logic [1:0]  rr;
        int          sent;
        int          budget;
        bit          presenting;
        bit          burst_err;
        burst_err = (nbeats != int'(cl_len[g]) + 1) || bad_rid;
        d  = '0;
        rr = '0;
        for (int i = 0; i <= ar_delay; i++) begin
            mem_if.mem_arready = (i == ar_delay);
            #1;
            chk("arvalid", mem_if.mem_arvalid, 1);
            chk("arid", mem_if.mem_arid, ID_BASE + 8'(g));
            chk("araddr", mem_if.mem_araddr, cl_addr[g]);
            chk("arlen", mem_if.mem_arlen, cl_len[g]);
            chk("arsize", mem_if.mem_arsize, 3'b010);
            chk("arburst", mem_if.mem_arburst, 2'b01);
            cyc();
        end
        mem_if.mem_arready = 1'b0;
        #1;
        chk("data_state", dbg_state, 2);
        sent       = 0;
        budget     = 0;
        presenting = 1'b0;
        while (sent < nbeats && budget < 2000) begin
            if (!presenting && ($urandom_range(0, 99) >= gap_pct)) begin
                d  = (data_base != 0) ? data_base + 32'(sent) : $urandom;
                rr = 2'($urandom_range(0, 3));
                exp_q.push_back(d);
                presenting = 1'b1;
            end
            mem_if.mem_rvalid = presenting;
            mem_if.mem_rdata  = d;
            mem_if.mem_rresp  = rr;
            mem_if.mem_rlast  = presenting && (sent == nbeats - 1);
            mem_if.mem_rid    = bad_rid ? ((ID_BASE + 8'(g)) ^ 8'h80) : ID_BASE + 8'(g);
            if (rmode == 0) begin
                req_if.req_rready = '1;
            end else begin
                req_if.req_rready = NUM_REQ'($urandom);
                if (rmode == 1) req_if.req_rready[g] = budget[0];
            end
            #1;
            chk("mem_rready", mem_if.mem_rready, req_if.req_rready[g]);
            chk("rvalid", req_if.req_rvalid, presenting ? onehot(g) : '0);
            if (presenting && req_if.req_rready[g]) begin
                chk("rdata", req_if.req_rdata, exp_q.pop_front());
                chk("rlast", req_if.req_rlast, sent == nbeats - 1);
                chk("rresp", req_if.req_rresp, rr);
                m_perf[g]  = perf_inc(m_perf[g]);
                sent++;
                presenting = 1'b0;
            end
            cyc();
            budget++;
        end
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rlast  = 1'b0;
        req_if.req_rready = '0;
        chk("beats_done", sent, nbeats);
        if (burst_err) m_err = 1'b1;
        m_ptr = (g + 1) % NUM_REQ;
        #1;
        chk("err_after_burst", err, m_err);
        chk("end_state_idle", dbg_state, 0);
        chk("exp_q_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        m_err   = 1'b0;
        #1;
        chk("err_clr", err, 0);
    endtask

    task automatic pulse_perf_clr();
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_perf[i] = '0;
        #1;
        chk_perf("perf_clr");
    endtask

    initial begin
        int g;
        int len;
        int nb;
        clear_inputs();
        model_reset();
        #2;
        do_reset();

        // Single request to client 0
        set_req(0, 32'h0000_1000, 8'd3);
        request(2'b01, g);
        req_if.req_arvalid = '0;
        serve(g, 4, 0, 0, 1'b0, 0, 32'h0000_00A0);
        chk_perf("perf_single");

        // Contention: both clients stay valid for four back-to-back bursts
        do_reset();
        set_req(0, 32'h0000_2000, 8'd0);
        set_req(1, 32'h0000_3000, 8'd0);
        for (int i = 0; i < 4; i++) begin
            request(2'b11, g);
            serve(g, 1, 0, 0, 1'b0, 0, 32'h0);
        end
        req_if.req_arvalid = '0;

        // Backpressure on AR then toggling client ready
        set_req(1, 32'h4000_0040, 8'd5);
        request(2'b10, g);
        req_if.req_arvalid = '0;
        serve(g, 6, 5, 1, 1'b0, 0, 32'h0);

        // Early rlast raises err; the flag is cleared afterwards
        set_req(0, 32'h0000_5000, 8'd1);
        request(2'b01, g);
        req_if.req_arvalid = '0;
        serve(g, 1, 0, 0, 1'b0, 0, 32'h0);
        pulse_err_clr();

        // Stray rvalid in IDLE coinciding with err_clr: set wins
        mem_if.mem_rvalid = 1'b1;
        err_clr           = 1'b1;
        cyc();
        mem_if.mem_rvalid = 1'b0;
        err_clr           = 1'b0;
        m_err             = 1'b1;
        #1;
        chk("set_wins", err, m_err);
        pulse_err_clr();

        // Wrong rid on a data beat
        set_req(1, 32'h0000_7000, 8'd0);
        request(2'b10, g);
        req_if.req_arvalid = '0;
        serve(g, 1, 0, 0, 1'b1, 0, 32'h0);
        pulse_err_clr();

        // Randomized bursts
        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < NUM_REQ; c++) begin
                set_req(c, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)));
            end
            request(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), g);
            req_if.req_arvalid = '0;
            len = int'(cl_len[g]);
            nb  = len + 1;
            if ($urandom_range(0, 9) == 0) begin
                nb = (len > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len) : len + 2;
            end
            serve(g, nb, $urandom_range(0, 3), 2, ($urandom_range(0, 9) == 0), 30, 32'h0);
            chk_perf("perf_rand");
            if (m_err) pulse_err_clr();
            if (it == 15) pulse_perf_clr();
        end

        // Beat counters: three 8-beat bursts to client 0
        pulse_perf_clr();
        for (int i = 0; i < 3; i++) begin
            set_req(0, 32'h0000_8000 + 32'(i * 32), 8'd7);
            request(2'b01, g);
            req_if.req_arvalid = '0;
            serve(g, 8, 0, 0, 1'b0, 0, 32'h0);
        end
        chk_perf("perf_24");
        pulse_perf_clr();

        // Reset during the third data beat
        set_req(0, 32'h0000_6000, 8'd3);
        request(2'b01, g);
        req_if.req_arvalid = '0;
        mem_if.mem_arready = 1'b1;
        cyc();
        mem_if.mem_arready = 1'b0;
        mem_if.mem_rid     = ID_BASE;
        req_if.req_rready  = '1;
        for (int b = 0; b < 2; b++) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = 32'(b);
            cyc();
        end
        mem_if.mem_rdata = 32'd2;
        #1;
        chk("mid_state", dbg_state, 2);
        chk("mid_rvalid", req_if.req_rvalid, onehot(0));
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        clear_inputs();
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        set_req(1, 32'h0000_9000, 8'd1);
        request(2'b10, g);
        req_if.req_arvalid = '0;
        serve(g, 2, 0, 0, 1'b0, 0, 32'h0);
        chk_perf("perf_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hs_npu_mem_rd_arbiter.md
Name: hs_npu_mem_rd_arbiter

Overview:
- Round-robin arbiter that shares the NPU's single AXI4 (axib) read address/data channel pair between NUM_REQ internal read clients, e.g. weight fetch, activation fetch and instruction fetch.
- Sits between the internal fetch engines and the top-level mem master read channels.
- One burst in flight at a time.
- R beats are routed back to the granted client; burst-length mismatches are flagged.

Parameters:
- NUM_REQ, 2: number of read clients (2..4).
- ID_BASE, 8'h10: arid = ID_BASE | grant index.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_arvalid  in  NUM_REQ  per-client read request valid
- req_arready  out  NUM_REQ  per-client request accept pulse
- req_araddr  in  NUM_REQ*32  per-client byte address, client i at [32i+31:32i]
- req_arlen  in  NUM_REQ*8  per-client AXI len (beats-1)
- req_rvalid  out  NUM_REQ  per-client read data valid
- req_rready  in  NUM_REQ  per-client read data ready
- req_rdata  out  32  read data, shared bus, qualified by req_rvalid
- req_rlast  out  1  last beat, shared, qualified by req_rvalid
- req_rresp  out  2  response, shared, qualified by req_rvalid
- mem_arvalid  out  1  AXI AR valid
- mem_arready  in  1  AXI AR ready
- mem_arid  out  8  AXI AR id
- mem_araddr  out  32  AXI AR address
- mem_arlen  out  8  AXI AR len
- mem_arsize  out  3  constant 3'b010
- mem_arburst  out  2  constant 2'b01 (INCR)
- mem_rvalid  in  1  AXI R valid
- mem_rready  out  1  AXI R ready
- mem_rid  in  8  AXI R id
- mem_rdata  in  32  AXI R data
- mem_rresp  in  2  AXI R resp
- mem_rlast  in  1  AXI R last
- err  out  1  sticky protocol error
- err_clr  in  1  clears err
- perf_beats  out  NUM_REQ*32  per-client beat counters (optional feature)
- perf_clr  in  1  clears perf_beats

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. The reset value of every output is 0, except mem_arsize and mem_arburst, which are constants. Reset sets state to IDLE and the priority pointer to 0.
- FSM states are IDLE, ADDR and DATA.
- IDLE:
  - If any req_arvalid is high, select the first requester at or after ptr, modulo NUM_REQ.
  - In the same cycle: pulse req_arready[g]=1, latch araddr/arlen, store g, go to ADDR.
  - req_arready is combinational from req_arvalid in IDLE only.
- ADDR:
  - mem_arvalid=1, with latched addr/len and arid=ID_BASE|g.
  - Hold all AR fields stable until mem_arready; then go to DATA.
  - Beat counter = 0.
- DATA:
  - req_rvalid[g]=mem_rvalid; other clients' rvalid=0.
  - mem_rready=req_rready[g].
  - rdata/rresp/rlast pass through combinationally.
  - Each handshake increments the beat counter.
  - On a handshake with mem_rlast=1: go to IDLE, set ptr=(g+1) mod NUM_REQ.
- Latency: client arvalid at cycle t gives mem_arvalid at t+1. There is one IDLE bubble cycle between consecutive bursts.
- Fairness: a requester that is continuously valid waits at most NUM_REQ-1 bursts.
- Errors (set err, sticky):
  - mem_rvalid in IDLE or ADDR.
  - mem_rid != ID_BASE|g on a DATA handshake.
  - rlast on beat != arlen.
  - Beat count exceeds arlen without rlast.
- Error handling:
  - Beats are still forwarded and the FSM still follows mem_rlast.
  - err_clr clears err. If err_clr coincides with a new error, err is 1 (set wins).
- A client withdrawing arvalid before arready is permitted; no grant is issued.
- Crossing 4 KB boundaries is the client's responsibility and is not checked.
- Reset mid-burst: the FSM returns to IDLE immediately and the outstanding AXI burst is abandoned. The system must reset the memory side together with this block.

Optional Feature:
- Macro: HS_NPU_RD_ARB_PERF_EN.
- When defined:
  - perf_beats[i] increments on each DATA handshake for client i and saturates at 32'hFFFF_FFFF.
  - perf_clr zeroes all counters. If perf_clr coincides with a beat, the counter clears (clear wins).
- When undefined: counters are not built, perf_beats is tied to 0 and perf_clr is ignored. The port list is unchanged.

Test Plan:
- Single request: client0 araddr=0x1000, arlen=3, memory returns 4 beats 0xA0..0xA3.
  - Expect mem_arid=0x10 and mem_araddr=0x1000 one cycle after the request.
  - Expect client0 to receive 4 beats with rlast on the 4th, and err=0.
- Contention: both clients continuously valid, arlen=0.
  - Grants alternate 0,1,0,1 across 4 bursts; arid alternates 0x10/0x11.
- Backpressure: mem_arready low for 5 cycles, then req_rready[1] toggling.
  - AR fields stay stable throughout.
  - No beat is lost or duplicated, and mem_rready mirrors req_rready[1].
- Length error: arlen=1 and memory asserts rlast on beat 0.
  - err=1 after that beat and the FSM returns to IDLE.
  - err_clr pulse then gives err=0.
- Reset mid-burst: rst_n low during DATA beat 2.
  - All outputs go to 0 asynchronously and the state is IDLE.
  - After release, a client1 request is granted first (ptr=0, client0 idle).
- Perf (macro defined): 3 bursts of arlen=7 to client0.
  - perf_beats[0]=24 and perf_beats[1]=0.
  - perf_clr then gives 0.
